// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the elastic pipeline stage
//
// Purpose: field positions inside the control word, result-source encodings,
// packed lane indices for the stage payload, and pointer-width helper.
// Ports: none (package).

package pipe_pkg;

    // Control field layout (bit 0 is regWrite, result source sits above it)
    localparam int CTRL_W_DEF         = 3;
    localparam int CTRL_REGWRITE_BIT  = 0;
    localparam int CTRL_RESULTSRC_LSB = 1;
    localparam int RESULTSRC_W        = 2;

    typedef enum logic [RESULTSRC_W-1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Lane positions inside the packed data bus, lane 0 in the LSBs
    localparam int LANES_DEF = 4;
    localparam int LANE_ALU  = 0;
    localparam int LANE_RD   = 1;
    localparam int LANE_PC4  = 2;
    localparam int LANE_IMM  = 3;

    // A one-entry buffer still needs a 1-bit pointer to keep vectors legal
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_wrap_ctr.sv
// rtl/pipe_wrap_ctr.sv - modulo-DEPTH pointer with increment and clear
//
// Purpose: circular-buffer pointer counting 0..DEPTH-1 and wrapping to 0.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset (pointer to 0)
//   clr_i  - synchronous clear, wins over increment
//   inc_i  - advance by one with wrap
//   ptr_o  - current pointer value

module pipe_wrap_ctr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - stallable, flushable elastic pipeline stage register
//
// Purpose: DEPTH-entry in-order buffer carrying ctrl, tag and LANES data words
// across a pipeline boundary with a valid/ready handshake.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   flush                    - synchronous discard of all entries (beats push/pop)
//   in_valid / in_ready      - upstream handshake
//   in_ctrl, in_tag, in_data - entry being offered
//   out_valid / out_ready    - downstream handshake
//   out_ctrl, out_tag        - head fields (zeroed on bubbles if ZERO_ON_BUBBLE)
//   out_data                 - head data, never masked
//   occupancy                - entries currently held

module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int LANES          = LANES_DEF,
    parameter int TAG_W          = 5,
    parameter int CTRL_W         = CTRL_W_DEF,
    parameter int DEPTH          = 2,
    parameter int ZERO_ON_BUBBLE = 1,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PAY_W = LANES * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [PAY_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [TAG_W-1:0]  out_tag,
    output logic [PAY_W-1:0]  out_data,
    output logic [CNT_W-1:0]  occupancy
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             push;
    logic             pop;

    // Payload storage is a plain register array so the head read is
    // asynchronous; it carries no reset because only control state matters.
    logic [CTRL_W-1:0] ctrl_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [PAY_W-1:0]  data_mem [DEPTH];

    assign full      = (count_q == CNT_W'(DEPTH));
    // A full stage can still take a word when the head leaves in the same
    // cycle; this is the only combinational path through the stage.
    assign in_ready  = !full || out_ready;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    pipe_wrap_ctr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    pipe_wrap_ctr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    // A push coinciding with flush is dropped, so it need not be written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            ctrl_mem[wr_ptr] <= in_ctrl;
            tag_mem[wr_ptr]  <= in_tag;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Bubbles present ctrl/tag as zero so regWrite cannot fire downstream.
    always_comb begin
        out_ctrl = ctrl_mem[rd_ptr];
        out_tag  = tag_mem[rd_ptr];
        if ((ZERO_ON_BUBBLE != 0) && !out_valid) begin
            out_ctrl = '0;
            out_tag  = '0;
        end
    end

    assign out_data = data_mem[rd_ptr];

endmodule
